lag_tile_injector: RTL and testbench

LAG_TILE_INJECTOR -- requirements
Module: lag_tile_injector

---
 rtl/lag_tile_injector.sv | 170 +++++++++++++++++
 tb/tb_lag_tile_injector.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_tile_injector.sv
// Tile traffic injector: accepts packet requests, picks an entry PL
// round-robin, then emits the packet's flits with per-PL backpressure.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pkt_valid/pkt_ready request handshake (ready only when idle)
//   pkt_xdest/ydest/len request fields (len 0 is treated as 1)
//   input_full_flag     per-PL full indication from the router input
//   flit_out            registered flit, all-zero when nothing emitted
//   busy                high whenever not idle
//   pkts_sent           tail flits emitted (wraps)
//   flits_sent          valid flits emitted (wraps)

package lag_pkg;
  localparam int router_num_pls_on_entry = 4;
  localparam int PL_W = 2;

  typedef struct packed {
    logic            valid;
    logic [PL_W-1:0] pl;
    logic            head;
    logic            tail;
  } flit_ctrl_t;

  typedef struct packed {
    logic [3:0] xsrc;
    logic [3:0] ysrc;
    logic [3:0] xdest;
    logic [3:0] ydest;
    logic [3:0] flit_id;
    logic [3:0] hops;
  } flit_dbg_t;

  typedef struct packed {
    flit_ctrl_t control;
    flit_dbg_t  debug;
  } flit_t;
endpackage

module lag_tile_injector
  import lag_pkg::*;
#(
  parameter logic [3:0] XSRC      = 4'd0,
  parameter logic [3:0] YSRC      = 4'd0,
  parameter int         NPL_ENTRY = router_num_pls_on_entry
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  input  logic [3:0]           pkt_xdest,
  input  logic [3:0]           pkt_ydest,
  input  logic [3:0]           pkt_len,
  input  logic [NPL_ENTRY-1:0] input_full_flag,
  output flit_t                flit_out,
  output logic                 busy,
  output logic [31:0]          pkts_sent,
  output logic [31:0]          flits_sent
);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    SEND
  } state_t;

  state_t          r_state;
  logic [PL_W-1:0] r_last_pl;
  logic [PL_W-1:0] r_sel_pl;
  logic [3:0]      r_xdest;
  logic [3:0]      r_ydest;
  logic [3:0]      r_len;
  logic [3:0]      r_flit_id;
  flit_t           r_flit;
  logic [31:0]     r_pkts;
  logic [31:0]     r_flits;

  logic [PL_W-1:0] w_sel;
  logic [PL_W-1:0] w_cand;
  logic            w_any;
  logic            w_emit;
  logic            w_tail;
  flit_t           w_flit;

  // Descending offsets so the nearest free PL after last_pl wins.
  always_comb begin
    w_sel  = '0;
    w_cand = '0;
    w_any  = 1'b0;
    for (int k = NPL_ENTRY; k >= 1; k--) begin
      w_cand = PL_W'((int'(r_last_pl) + k) % NPL_ENTRY);
      if (!input_full_flag[w_cand]) begin
        w_sel = w_cand;
        w_any = 1'b1;
      end
    end
  end

  assign w_emit = (r_state == SEND) &&
                  !input_full_flag[r_sel_pl];
  assign w_tail = (r_flit_id == r_len);

  always_comb begin
    w_flit                = '0;
    w_flit.control.valid  = 1'b1;
    w_flit.control.pl     = r_sel_pl;
    w_flit.control.head   = (r_flit_id == 4'd1);
    w_flit.control.tail   = w_tail;
    w_flit.debug.xsrc     = XSRC;
    w_flit.debug.ysrc     = YSRC;
    w_flit.debug.xdest    = r_xdest;
    w_flit.debug.ydest    = r_ydest;
    w_flit.debug.flit_id  = r_flit_id;
    w_flit.debug.hops     = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last_pl <= PL_W'(NPL_ENTRY - 1);
      r_sel_pl  <= '0;
      r_xdest   <= '0;
      r_ydest   <= '0;
      r_len     <= 4'd1;
      r_flit_id <= 4'd1;
      r_flit    <= '0;
      r_pkts    <= '0;
      r_flits   <= '0;
    end else begin
      r_flit <= '0;
      case (r_state)
        IDLE: begin
          if (pkt_valid) begin
            r_xdest   <= pkt_xdest;
            r_ydest   <= pkt_ydest;
            r_len     <= (pkt_len == 4'd0) ? 4'd1 : pkt_len;
            r_flit_id <= 4'd1;
            r_state   <= ARB;
          end
        end
        ARB: begin
          if (w_any) begin
            r_sel_pl  <= w_sel;
            r_last_pl <= w_sel;
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (w_emit) begin
            r_flit    <= w_flit;
            r_flit_id <= r_flit_id + 4'd1;
            r_flits   <= r_flits + 32'd1;
            if (w_tail) begin
              r_pkts  <= r_pkts + 32'd1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flit_out   = r_flit;
  assign busy       = (r_state != IDLE);
  assign pkt_ready  = (r_state == IDLE);
  assign pkts_sent  = r_pkts;
  assign flits_sent = r_flits;

endmodule

// File: tb/tb_lag_tile_injector.sv
// Bench for lag_tile_injector: table of packets, directed
// corner sequences, and randomized traffic against a model.

module tb_lag_tile_injector;
  import lag_pkg::*;

  localparam int NPL = router_num_pls_on_entry;
  localparam logic [3:0] XS = 4'd3;
  localparam logic [3:0] YS = 4'd5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           pkt_valid;
  logic           pkt_ready;
  logic [3:0]     pkt_xdest;
  logic [3:0]     pkt_ydest;
  logic [3:0]     pkt_len;
  logic [NPL-1:0] flags;
  flit_t          flit_out;
  logic           busy;
  logic [31:0]    pkts_sent;
  logic [31:0]    flits_sent;

  lag_tile_injector #(
    .XSRC(XS),
    .YSRC(YS),
    .NPL_ENTRY(NPL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_xdest(pkt_xdest),
    .pkt_ydest(pkt_ydest),
    .pkt_len(pkt_len),
    .input_full_flag(flags),
    .flit_out(flit_out),
    .busy(busy),
    .pkts_sent(pkts_sent),
    .flits_sent(flits_sent)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Packet-level model: one job at a time; the job first waits
  // for a PL choice, then counts flits sent on that PL.
  bit          m_job;
  int          m_len;
  logic [3:0]  m_x;
  logic [3:0]  m_y;
  int          m_sent;
  int          m_pl;
  int          m_last;
  logic [31:0] m_pkts;
  logic [31:0] m_flits;
  flit_t       m_flit;

  task automatic model_update();
    if (!rst_n) begin
      m_job   = 1'b0;
      m_pkts  = '0;
      m_flits = '0;
      m_last  = NPL - 1;
      m_flit  = '0;
    end else begin
      m_flit = '0;
      if (!m_job) begin
        if (pkt_valid) begin
          m_job  = 1'b1;
          m_len  = (pkt_len == 0) ? 1 : int'(pkt_len);
          m_x    = pkt_xdest;
          m_y    = pkt_ydest;
          m_sent = 0;
          m_pl   = -1;
        end
      end else if (m_pl < 0) begin
        for (int o = 1; o <= NPL; o++) begin
          int c = (m_last + o) % NPL;
          if (!flags[c]) begin
            m_pl   = c;
            m_last = c;
            break;
          end
        end
      end else if (!flags[m_pl]) begin
        m_sent++;
        m_flit.control.valid = 1'b1;
        m_flit.control.pl    = PL_W'(m_pl);
        m_flit.control.head  = (m_sent == 1);
        m_flit.control.tail  = (m_sent == m_len);
        m_flit.debug.xsrc    = XS;
        m_flit.debug.ysrc    = YS;
        m_flit.debug.xdest   = m_x;
        m_flit.debug.ydest   = m_y;
        m_flit.debug.flit_id = 4'(m_sent);
        m_flit.debug.hops    = 4'd0;
        m_flits++;
        if (m_sent == m_len) begin
          m_pkts++;
          m_job = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pkt_valid = 1'b0;
    step();
    chk("rst_ready", 64'(pkt_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flit", 64'(flit_out), 64'd0);
    chk("rst_pkts", 64'(pkts_sent), 64'd0);
    chk("rst_flits", 64'(flits_sent), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic accept(input logic [3:0] len,
                        input logic [3:0] x,
                        input logic [3:0] y);
    chk("acc_ready", 64'(pkt_ready), 64'd1);
    pkt_valid = 1'b1;
    pkt_len   = len;
    pkt_xdest = x;
    pkt_ydest = y;
    step();
    // Changes after acceptance must be ignored.
    pkt_valid = 1'b1;
    pkt_len   = 4'(~len);
    pkt_xdest = 4'(~x);
    pkt_ydest = 4'(~y);
  endtask

  task automatic check_flit(input int id, input int n,
                            input int pl,
                            input logic [3:0] x,
                            input logic [3:0] y);
    chk("flit_pl", 64'(flit_out.control.pl), 64'(pl));
    chk("flit_id", 64'(flit_out.debug.flit_id), 64'(id));
    chk("flit_head", 64'(flit_out.control.head),
        64'(id == 1));
    chk("flit_tail", 64'(flit_out.control.tail),
        64'(id == n));
    chk("flit_dbg",
        {40'd0, flit_out.debug.xsrc, flit_out.debug.ysrc,
         flit_out.debug.xdest, flit_out.debug.ydest,
         flit_out.debug.hops},
        {40'd0, XS, YS, x, y, 4'd0});
  endtask

  task automatic run_pkt(input logic [3:0] len,
                         input logic [3:0] x,
                         input logic [3:0] y,
                         input logic [NPL-1:0] fl,
                         input int pl, input int n);
    int got;
    flags = fl;
    accept(len, x, y);
    pkt_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 60 && got < n; c++) begin
      step();
      if (flit_out.control.valid) begin
        got++;
        check_flit(got, n, pl, x, y);
      end
    end
    chk("pkt_flit_count", 64'(got), 64'(n));
    step();
    chk("pkt_back_idle", 64'(pkt_ready), 64'd1);
  endtask

  typedef struct {
    logic [3:0]     len;
    logic [3:0]     x;
    logic [3:0]     y;
    logic [NPL-1:0] fl;
    int             pl;
    int             n;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int exp_p;
    int exp_f;
    int got;
    bit seen;
    rst_n     = 1'b0;
    pkt_valid = 1'b0;
    pkt_len   = '0;
    pkt_xdest = '0;
    pkt_ydest = '0;
    flags     = '0;

    tbl[0] = '{4'd3,  4'd2, 4'd1, 4'b0000, 0, 3};
    tbl[1] = '{4'd0,  4'd7, 4'd9, 4'b0000, 1, 1};
    tbl[2] = '{4'd1,  4'd4, 4'd6, 4'b0000, 2, 1};
    tbl[3] = '{4'd5,  4'd1, 4'd8, 4'b1000, 0, 5};
    tbl[4] = '{4'd2,  4'hf, 4'h0, 4'b0110, 3, 2};
    tbl[5] = '{4'd15, 4'ha, 4'hb, 4'b0000, 0, 15};

    do_reset();
    exp_p = 0;
    exp_f = 0;
    foreach (tbl[i]) begin
      run_pkt(tbl[i].len, tbl[i].x, tbl[i].y,
              tbl[i].fl, tbl[i].pl, tbl[i].n);
      exp_p++;
      exp_f += tbl[i].n;
      chk("tbl_pkts", 64'(pkts_sent), 64'(exp_p));
      chk("tbl_flits", 64'(flits_sent), 64'(exp_f));
    end

    // Stall on the selected PL for two cycles after flit 2.
    do_reset();
    flags = '0;
    accept(4'd4, 4'd2, 4'd2);
    pkt_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      step();
      if (flit_out.control.valid) got++;
    end
    chk("stall_pre", 64'(got), 64'd2);
    flags = 4'b0001;
    step();
    chk("stall_gap1", 64'(flit_out.control.valid), 64'd0);
    step();
    chk("stall_gap2", 64'(flit_out.control.valid), 64'd0);
    flags = 4'b1110;
    step();
    chk("stall_v3", 64'(flit_out.control.valid), 64'd1);
    check_flit(3, 4, 0, 4'd2, 4'd2);
    step();
    chk("stall_v4", 64'(flit_out.control.valid), 64'd1);
    check_flit(4, 4, 0, 4'd2, 4'd2);
    flags = '0;
    step();

    // Round-robin skipping full PLs, then rotating.
    do_reset();
    run_pkt(4'd1, 4'd1, 4'd1, 4'b0011, 2, 1);
    run_pkt(4'd1, 4'd1, 4'd1, 4'b0000, 3, 1);
    run_pkt(4'd1, 4'd1, 4'd1, 4'b0000, 0, 1);

    // All PLs full: hold in arbitration.
    do_reset();
    flags = 4'b1111;
    accept(4'd2, 4'd3, 4'd4);
    pkt_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("full_valid", 64'(flit_out.control.valid), 64'd0);
      chk("full_ready", 64'(pkt_ready), 64'd0);
      chk("full_busy", 64'(busy), 64'd1);
    end
    flags = 4'b1101;
    seen = 1'b0;
    for (int c = 0; c < 2 && !seen; c++) begin
      step();
      if (flit_out.control.valid) begin
        seen = 1'b1;
        check_flit(1, 2, 1, 4'd3, 4'd4);
      end
    end
    chk("full_head_seen", 64'(seen), 64'd1);
    flags = '0;
    step();
    step();

    // Reset in the middle of a packet.
    do_reset();
    accept(4'd4, 4'd5, 4'd5);
    pkt_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      step();
      if (flit_out.control.valid) got++;
    end
    chk("mid_pre", 64'(got), 64'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_valid", 64'(flit_out.control.valid), 64'd0);
    chk("mid_pkts", 64'(pkts_sent), 64'd0);
    chk("mid_flits", 64'(flits_sent), 64'd0);
    chk("mid_ready", 64'(pkt_ready), 64'd1);
    got = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (flit_out.control.valid) got++;
    end
    chk("mid_no_tail", 64'(got), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(299) != 0);
      pkt_valid = ($urandom_range(2) != 0);
      pkt_len   = 4'($urandom_range(15));
      pkt_xdest = 4'($urandom);
      pkt_ydest = 4'($urandom);
      for (int b = 0; b < NPL; b++)
        flags[b] = ($urandom_range(9) < 3);
      step();
      chk("rnd_flit", 64'(flit_out), 64'(m_flit));
      chk("rnd_ctl", {62'd0, pkt_ready, busy},
          {62'd0, !m_job, m_job});
      chk("rnd_cnt", {pkts_sent, flits_sent},
          {m_pkts, m_flits});
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
